// File: rtl/cam_ctrl.sv
// Command sequencer for the CAM row array: serialises READ/WRITE/WRITE_FREE/SEARCH
// onto the shared row buses and returns one registered response per command.
module cam_ctrl #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [IDXW-1:0]        cmd_index_i,
  input  logic [WIDTH-1:0]       cmd_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_data_o,
  output logic [IDXW-1:0]        rsp_index_o,
  output logic                   rsp_hit_o,
  output logic                   rsp_err_o,
  output logic [WIDTH-1:0]       row_wdata_o,
  output logic [DEPTH-1:0]       row_we_o,
  output logic                   row_search_en_o,
  output logic [WIDTH-1:0]       row_search_data_o,
  input  logic [DEPTH*WIDTH-1:0] row_rdata_i,
  input  logic [DEPTH-1:0]       row_match_i,
  input  logic [DEPTH-1:0]       row_valid_i
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_WFREE = 2'b10;
  localparam logic [1:0] OP_SRCH  = 2'b11;

  typedef enum logic [2:0] {IDLE, WR, RD, SRCH, EVAL, RSP} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [IDXW-1:0]   res_idx_q, res_idx_d;
  logic              res_hit_q, res_hit_d;
  logic              res_err_q, res_err_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [IDXW-1:0]   rsp_index_q, rsp_index_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]  row_wdata_q, row_wdata_d;
  logic [DEPTH-1:0]  row_we_q, row_we_d;
  logic              row_search_en_q, row_search_en_d;
  logic [WIDTH-1:0]  row_search_data_q, row_search_data_d;

  logic [DEPTH-1:0]  hit_vec;
  logic              hit_found, free_found;
  logic [IDXW-1:0]   hit_idx, free_idx;
  logic [WIDTH-1:0]  rd_word, hit_word;

  assign rd_word  = row_rdata_i[idx_q*WIDTH +: WIDTH];
  assign hit_word = row_rdata_i[hit_idx*WIDTH +: WIDTH];

  // Lowest-index priority encoders: first matching valid row, first invalid row
  always_comb begin
    hit_vec    = row_match_i & row_valid_i;
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int r = int'(DEPTH) - 1; r >= 0; r--) begin
      if (hit_vec[r]) begin
        hit_found = 1'b1;
        hit_idx   = IDXW'(r);
      end
      if (!row_valid_i[r]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(r);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    data_d            = data_q;
    res_data_d        = res_data_q;
    res_idx_d         = res_idx_q;
    res_hit_d         = res_hit_q;
    res_err_d         = res_err_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_data_d        = rsp_data_q;
    rsp_index_d       = rsp_index_q;
    rsp_hit_d         = rsp_hit_q;
    rsp_err_d         = rsp_err_q;
    row_wdata_d       = '0;
    row_we_d          = '0;
    row_search_en_d   = 1'b0;
    row_search_data_d = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          idx_d      = cmd_index_i;
          data_d     = cmd_data_i;
          res_data_d = '0;
          res_idx_d  = cmd_index_i;
          res_hit_d  = 1'b0;
          res_err_d  = 1'b0;
          case (cmd_op_i)
            OP_READ:  state_d = RD;
            OP_WRITE: state_d = WR;
            OP_WFREE: begin
              if (free_found) begin
                idx_d     = free_idx;
                res_idx_d = free_idx;
                state_d   = WR;
              end else begin
                res_idx_d = '0;
                res_err_d = 1'b1;
                state_d   = RSP;
              end
            end
            OP_SRCH: begin
              res_idx_d = '0;
              state_d   = SRCH;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      WR: begin
        row_we_d    = DEPTH'(1) << idx_q;
        row_wdata_d = data_q;
        state_d     = RSP;
      end
      RD: begin
        res_data_d = rd_word;
        res_hit_d  = row_valid_i[idx_q];
        state_d    = RSP;
      end
      SRCH: begin
        row_search_en_d   = 1'b1;
        row_search_data_d = data_q;
        state_d           = EVAL;
      end
      EVAL: begin
        row_search_en_d   = 1'b1;
        row_search_data_d = data_q;
        res_hit_d         = hit_found;
        res_idx_d         = hit_idx;
        res_data_d        = hit_found ? hit_word : '0;
        state_d           = RSP;
      end
      RSP: begin
        // Present the captured result once, then hold until the consumer takes it
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = res_data_q;
          rsp_index_d = res_idx_q;
          rsp_hit_d   = res_hit_q;
          rsp_err_d   = res_err_q;
        end else if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_index_d = '0;
          rsp_hit_d   = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      data_q            <= '0;
      res_data_q        <= '0;
      res_idx_q         <= '0;
      res_hit_q         <= 1'b0;
      res_err_q         <= 1'b0;
      cmd_ready_q       <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= '0;
      rsp_index_q       <= '0;
      rsp_hit_q         <= 1'b0;
      rsp_err_q         <= 1'b0;
      row_wdata_q       <= '0;
      row_we_q          <= '0;
      row_search_en_q   <= 1'b0;
      row_search_data_q <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      data_q            <= data_d;
      res_data_q        <= res_data_d;
      res_idx_q         <= res_idx_d;
      res_hit_q         <= res_hit_d;
      res_err_q         <= res_err_d;
      cmd_ready_q       <= cmd_ready_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      rsp_index_q       <= rsp_index_d;
      rsp_hit_q         <= rsp_hit_d;
      rsp_err_q         <= rsp_err_d;
      row_wdata_q       <= row_wdata_d;
      row_we_q          <= row_we_d;
      row_search_en_q   <= row_search_en_d;
      row_search_data_q <= row_search_data_d;
    end
  end

  assign cmd_ready_o       = cmd_ready_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_index_o       = rsp_index_q;
  assign rsp_hit_o         = rsp_hit_q;
  assign rsp_err_o         = rsp_err_q;
  assign row_wdata_o       = row_wdata_q;
  assign row_we_o          = row_we_q;
  assign row_search_en_o   = row_search_en_q;
  assign row_search_data_o = row_search_data_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural row array and hand-computed responses.
module tb_cam_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned D = 8;

  logic           clk;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready_o;
  logic [1:0]     cmd_op;
  logic [2:0]     cmd_index;
  logic [W-1:0]   cmd_data;
  logic           rsp_valid_o;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data_o;
  logic [2:0]     rsp_index_o;
  logic           rsp_hit_o;
  logic           rsp_err_o;
  logic [W-1:0]   row_wdata_o;
  logic [D-1:0]   row_we_o;
  logic           row_search_en_o;
  logic [W-1:0]   row_search_data_o;
  logic [D*W-1:0] row_rdata;
  logic [D-1:0]   row_match;
  logic [D-1:0]   row_valid;

  int checks   = 0;
  int failures = 0;

  cam_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_op_i          (cmd_op),
    .cmd_index_i       (cmd_index),
    .cmd_data_i        (cmd_data),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready),
    .rsp_data_o        (rsp_data_o),
    .rsp_index_o       (rsp_index_o),
    .rsp_hit_o         (rsp_hit_o),
    .rsp_err_o         (rsp_err_o),
    .row_wdata_o       (row_wdata_o),
    .row_we_o          (row_we_o),
    .row_search_en_o   (row_search_en_o),
    .row_search_data_o (row_search_data_o),
    .row_rdata_i       (row_rdata),
    .row_match_i       (row_match),
    .row_valid_i       (row_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural row array: write on we, combinational read and compare
  logic [W-1:0] mem [D];
  logic [D-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int r = 0; r < int'(D); r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < int'(D); r++) begin
        if (row_we_o[r]) begin
          mem[r] <= row_wdata_o;
          vld[r] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_rdata = '0;
    row_match = '0;
    for (int r = 0; r < int'(D); r++) begin
      row_rdata[r*W +: W] = mem[r];
      row_match[r]        = row_search_en_o && (mem[r] == row_search_data_o);
    end
  end
  assign row_valid = vld;

  int           we_cycles;
  logic [D-1:0] last_we;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_cycles <= 0;
      last_we   <= '0;
    end else if (row_we_o != '0) begin
      we_cycles <= we_cycles + 1;
      last_we   <= row_we_o;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge (edge N + 1 time unit)
  task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [W-1:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_index = idx;
    cmd_data  = d;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    check_eq("cmd_ready_wait", 64'(cmd_ready_o), 64'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 0;
    while (!rsp_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic expect_rsp(input string tag, input logic [W-1:0] d, input logic [2:0] idx,
                            input logic hit, input logic err);
    check_eq({tag, "_data"}, 64'(rsp_data_o), 64'(d));
    check_eq({tag, "_idx"},  64'(rsp_index_o), 64'(idx));
    check_eq({tag, "_hit"},  64'(rsp_hit_o), 64'(hit));
    check_eq({tag, "_err"},  64'(rsp_err_o), 64'(err));
    check_eq({tag, "_busy"}, 64'(cmd_ready_o), 64'(0));
    tick();
    check_eq({tag, "_drop"}, 64'(rsp_valid_o), 64'(0));
    check_eq({tag, "_rdy"},  64'(cmd_ready_o), 64'(1));
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [2:0] idx,
                        input logic [W-1:0] d, input int lat, input logic [W-1:0] ed,
                        input logic [2:0] eidx, input logic ehit, input logic eerr,
                        input logic [D-1:0] exp_we);
    int we0 = we_cycles;
    send(op, idx, d);
    wait_rsp(tag, lat);
    expect_rsp(tag, ed, eidx, ehit, eerr);
    check_eq({tag, "_wecnt"}, 64'(we_cycles - we0), 64'(exp_we != '0));
    if (exp_we != '0) check_eq({tag, "_we"}, 64'(last_we), 64'(exp_we));
  endtask

  task automatic full_reset();
    rst_n = 1'b0;
    #1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_index = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check_eq("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
    check_eq("rst_we", 64'(row_we_o), 64'(0));
    check_eq("rst_srch_en", 64'(row_search_en_o), 64'(0));
    check_eq("rst_rsp_data", 64'(rsp_data_o), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("post_rst_ready", 64'(cmd_ready_o), 64'(1));

    // WRITE idx 3 with cycle-exact we pulse and response timing
    send(2'b01, 3'd3, 32'hDEADBEEF);
    check_eq("wr_we_n0", 64'(row_we_o), 64'(0));
    tick();
    check_eq("wr_we_n1", 64'(row_we_o), 64'h08);
    check_eq("wr_wdata_n1", 64'(row_wdata_o), 64'hDEADBEEF);
    check_eq("wr_rsp_n1", 64'(rsp_valid_o), 64'(0));
    tick();
    check_eq("wr_we_n2", 64'(row_we_o), 64'(0));
    check_eq("wr_rsp_n2", 64'(rsp_valid_o), 64'(1));
    expect_rsp("wr3", 32'h0, 3'd3, 1'b0, 1'b0);

    do_cmd("rd3", 2'b00, 3'd3, 32'h0, 2, 32'hDEADBEEF, 3'd3, 1'b1, 1'b0, 8'h00);
    do_cmd("rd5", 2'b00, 3'd5, 32'h0, 2, 32'h0, 3'd5, 1'b0, 1'b0, 8'h00);
    do_cmd("wr6", 2'b01, 3'd6, 32'hDEADBEEF, 2, 32'h0, 3'd6, 1'b0, 1'b0, 8'h40);
    do_cmd("srch_hit", 2'b11, 3'd0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 3'd3, 1'b1, 1'b0, 8'h00);
    do_cmd("srch_miss", 2'b11, 3'd5, 32'h12345678, 3, 32'h0, 3'd0, 1'b0, 1'b0, 8'h00);

    // Backpressure: response held stable while the consumer stalls
    rsp_ready = 1'b0;
    send(2'b00, 3'd6, 32'h0);
    wait_rsp("bp", 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", 64'(rsp_valid_o), 64'(1));
      check_eq("bp_data", 64'(rsp_data_o), 64'hDEADBEEF);
      check_eq("bp_idx", 64'(rsp_index_o), 64'(6));
      check_eq("bp_ready", 64'(cmd_ready_o), 64'(0));
    end
    rsp_ready = 1'b1;
    expect_rsp("bp", 32'hDEADBEEF, 3'd6, 1'b1, 1'b0);

    // Reset while the search bus is active
    send(2'b11, 3'd0, 32'hDEADBEEF);
    tick();
    check_eq("eval_en_on", 64'(row_search_en_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("eval_rst_en", 64'(row_search_en_o), 64'(0));
    check_eq("eval_rst_key", 64'(row_search_data_o), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid_o) seen++;
    end
    check_eq("eval_rst_norsp", 64'(seen), 64'(0));

    // Reset while the write enable is high
    send(2'b01, 3'd4, 32'h55AA55AA);
    tick();
    check_eq("wr_rst_we_on", 64'(row_we_o), 64'h10);
    rst_n = 1'b0;
    #1;
    check_eq("wr_rst_we", 64'(row_we_o), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid_o) seen++;
    end
    check_eq("wr_rst_norsp", 64'(seen), 64'(0));

    // Back-to-back write then search of the same word
    do_cmd("wr2", 2'b01, 3'd2, 32'hCAFEF00D, 2, 32'h0, 3'd2, 1'b0, 1'b0, 8'h04);
    do_cmd("srch2", 2'b11, 3'd7, 32'hCAFEF00D, 3, 32'hCAFEF00D, 3'd2, 1'b1, 1'b0, 8'h00);

    // WRITE_FREE fills an empty array in index order, then reports full
    full_reset();
    for (int i = 0; i < 8; i++) begin
      logic [D-1:0] onehot;
      onehot = D'(1) << i;
      do_cmd("wfree", 2'b10, 3'd5, 32'h10000000 + 32'(i), 2, 32'h0, 3'(i), 1'b0, 1'b0, onehot);
    end
    do_cmd("wfree_full", 2'b10, 3'd5, 32'hFFFFFFFF, 1, 32'h0, 3'd0, 1'b0, 1'b1, 8'h00);
    do_cmd("rd7_after", 2'b00, 3'd7, 32'h0, 2, 32'h10000007, 3'd7, 1'b1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Command sequencer for the CAM row array: it accepts READ, WRITE, WRITE_FREE and SEARCH commands over a valid/ready port and drives the rows' shared write-data, one-hot write-enable and search buses. It collects row data, match and valid vectors, priority-encodes search hits and returns one response per command over a second valid/ready port. It sits between the CAM's client logic and DEPTH instances of the row storage, and is the only agent writing or searching the array.

## Interface
- WIDTH, 32, entry width in bits (matches row WIDTH)
- DEPTH, 8, number of rows; power of two, ≥2
- IDXW, $clog2(DEPTH), row index width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  controller accepts command this cycle
- cmd_op_i  in  2  00 READ, 01 WRITE (to cmd_index_i), 10 WRITE_FREE (lowest invalid row), 11 SEARCH
- cmd_index_i  in  IDXW  target row for READ/WRITE
- cmd_data_i  in  WIDTH  write data or search key
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes response
- rsp_data_o  out  WIDTH  read data; matched row's data on SEARCH hit; else 0
- rsp_index_o  out  IDXW  row read/written/matched
- rsp_hit_o  out  1  READ: row valid; SEARCH: match found; writes: 0
- rsp_err_o  out  1  WRITE_FREE with no invalid row
- row_wdata_o  out  WIDTH  shared write data to all rows
- row_we_o  out  DEPTH  one-hot per-row write enable
- row_search_en_o  out  1  search enable to all rows
- row_search_data_o  out  WIDTH  search key to all rows
- row_rdata_i  in  DEPTH*WIDTH  row r data at bits [r*WIDTH +: WIDTH]
- row_match_i  in  DEPTH  per-row match
- row_valid_i  in  DEPTH  per-row valid (row read_valid_o)

## Operation
- FSM states: IDLE, WR, RD, SRCH, EVAL, RSP. All outputs registered.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch op/index/data and go to:
  - READ → RD; WRITE → WR.
  - WRITE_FREE: compute lowest r with row_valid_i[r]=0 at accept. If one exists → WR with index r. If none → RSP with err=1, no write.
  - SEARCH → SRCH.
- WR: row_we_o one-hot at latched index, row_wdata_o = latched data, for exactly one cycle → RSP (index=row, hit=0, err=0, data=0).
- RD: sample row_rdata_i slice and row_valid_i[index] → RSP (data, hit=valid bit).
- SRCH: row_search_en_o=1 and row_search_data_o=key → EVAL.
- EVAL: en/key held. At end of cycle, form hitvec = row_match_i & row_valid_i. Invalid rows never hit. Lowest set index wins → RSP (hit=|hitvec, index=winner or 0, data=winner's row_rdata_i or 0).
- RSP: rsp_valid_o=1; all rsp_* fields stable until rsp_ready_i. On handshake → IDLE.
- cmd_ready_o=0 in every state except IDLE (one command outstanding).
- rsp_err_o=1 only for WRITE_FREE-full. Any other response has err=0.

## Timing
- Reset asserted (reset=0): immediately IDLE. All outputs 0 except cmd_ready_o, which is 1 after release. row_we_o and row_search_en_o drop asynchronously. Any in-flight command and response is discarded.
- Accept at edge N. READ/WRITE/WRITE_FREE: rsp_valid_o high from edge N+2. SEARCH: from edge N+3. WRITE_FREE-full: from edge N+1.
- row_we_o is high during cycle N+1 only. Row becomes valid at edge N+2.
- With rsp_ready_i held high, the response lasts 1 cycle. The next command is accepted the cycle after the handshake.
- Back-to-back WRITE then SEARCH of the same data hits, since the row is valid before SRCH.
- Outputs to rows are 0 in every state not listed above. No glitching between states.

## Test plan
- Reset, then WRITE idx 3 data 0xDEADBEEF → row_we_o=0x08 for one cycle; response idx 3, hit 0, err 0 at accept+2.
- READ idx 3 → rsp_data 0xDEADBEEF, hit 1. READ idx 5 (never written) → hit 0.
- SEARCH 0xDEADBEEF with rows 3 and 6 holding it → hit 1, index 3, data 0xDEADBEEF at accept+3. SEARCH 0x12345678 → hit 0, index 0, data 0.
- Eight WRITE_FREE into an empty array → indices 0..7 in order. Ninth → err 1 at accept+1, no row_we_o pulse.
- Hold rsp_ready_i low 5 cycles → rsp_* stable, cmd_ready_o 0; release → IDLE next cycle.
- Assert reset during EVAL and during WR → row_search_en_o / row_we_o drop at once; no response after release; next command is served normally.
